// File: rtl/mem_access_if.sv
// Request/response bus of mem_access plus the port to its attached word memory.
// The slave modport is the access unit; the master modport is its environment (requester and RAM).
interface mem_access_if;
  logic        req;
  logic        ready;
  logic        wr;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        fault;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wd;
  logic [31:0] ram_data;

  modport master (
    output req, wr, size, uns, addr, wdata, ram_data,
    input  ready, rdata, done, fault, ram_we, ram_addr, ram_wd
  );

  modport slave (
    input  req, wr, size, uns, addr, wdata, ram_data,
    output ready, rdata, done, fault, ram_we, ram_addr, ram_wd
  );
endinterface

// File: rtl/mem_access.sv
// Byte/halfword/word load-store unit for a little-endian word memory with sub-word
// read-modify-write. Define MEM_ACCESS_BOUNDS_CHECK_EN to also fault accesses past ADDR_LIMIT.
module mem_access #(
  parameter int unsigned ADDR_LIMIT = 32768
) (
  input logic         clk,
  input logic         rst,
  mem_access_if.slave bus
);

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
  localparam bit BoundsEn = 1'b1;
`else
  localparam bit BoundsEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  state_e      state_q;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        wr_q;
  logic        uns_q;
  logic [15:0] wdata_q;
  logic [31:0] rdata_q;
  logic        done_q;
  logic        fault_q;
  logic        ram_we_q;
  logic [31:0] ram_addr_q;
  logic [31:0] ram_wd_q;

  logic        ready;
  logic        accept;
  logic        misaligned;
  logic        limit_hit;
  logic        reject;
  logic [1:0]  span;
  logic [32:0] last_byte;
  logic [4:0]  sh;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;
  logic [31:0] merged;

  assign ready  = (state_q == StIdle) && !rst;
  assign accept = bus.req && ready;

  // span is the byte count minus one, used for the last-byte address.
  always_comb begin
    misaligned = 1'b0;
    span       = 2'd0;
    case (bus.size)
      2'b00: span = 2'd0;
      2'b01: begin
        span       = 2'd1;
        misaligned = bus.addr[0];
      end
      2'b10: begin
        span       = 2'd3;
        misaligned = |bus.addr[1:0];
      end
      default: misaligned = 1'b1;
    endcase
  end

  assign last_byte = {1'b0, bus.addr} + {31'd0, span};
  assign limit_hit = last_byte >= 33'(ADDR_LIMIT);
  assign reject    = misaligned || (BoundsEn && limit_hit);

  // Addressed lane moved down to bit 0; words are aligned so their shift is zero.
  assign sh      = {off_q, 3'b000};
  assign shifted = bus.ram_data >> sh;

  always_comb begin
    load_val = shifted;
    case (size_q)
      2'b00:   load_val = uns_q ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = uns_q ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    lane_mask = 32'h0000_FFFF << sh;
    lane_data = {16'd0, wdata_q} << sh;
    if (size_q == 2'b00) begin
      lane_mask = 32'h0000_00FF << sh;
      lane_data = {24'd0, wdata_q[7:0]} << sh;
    end
    merged = (bus.ram_data & ~lane_mask) | (lane_data & lane_mask);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      off_q      <= 2'd0;
      size_q     <= 2'd0;
      wr_q       <= 1'b0;
      uns_q      <= 1'b0;
      wdata_q    <= 16'd0;
      rdata_q    <= 32'd0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= 32'd0;
      ram_wd_q   <= 32'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            off_q   <= bus.addr[1:0];
            size_q  <= bus.size;
            wr_q    <= bus.wr;
            uns_q   <= bus.uns;
            wdata_q <= bus.wdata[15:0];
            if (reject) begin
              state_q <= StResp;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
            end else if (bus.wr && bus.size == 2'b10) begin
              // Full-word stores skip the read and write straight away.
              state_q    <= StWr;
              ram_we_q   <= 1'b1;
              ram_addr_q <= {bus.addr[31:2], 2'b00};
              ram_wd_q   <= bus.wdata;
            end else begin
              state_q    <= StRd;
              ram_addr_q <= {bus.addr[31:2], 2'b00};
            end
          end
        end
        StRd: begin
          if (wr_q) begin
            state_q  <= StWr;
            ram_we_q <= 1'b1;
            ram_wd_q <= merged;
          end else begin
            state_q    <= StResp;
            rdata_q    <= load_val;
            done_q     <= 1'b1;
            ram_addr_q <= 32'd0;
          end
        end
        StWr: begin
          state_q    <= StResp;
          done_q     <= 1'b1;
          ram_we_q   <= 1'b0;
          ram_addr_q <= 32'd0;
          ram_wd_q   <= 32'd0;
        end
        StResp: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          fault_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ready    = ready;
  assign bus.rdata    = rdata_q;
  assign bus.done     = done_q;
  assign bus.fault    = fault_q;
  assign bus.ram_we   = ram_we_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_wd   = ram_wd_q;

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access: a transaction-level model predicts every post-acceptance
// cycle, and one negedge process compares the DUT against those predictions.
module tb_mem_access;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_if bus ();

  mem_access #(
    .ADDR_LIMIT(32768)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
  localparam bit BoundsEn = 1'b1;
`else
  localparam bit BoundsEn = 1'b0;
`endif

  logic [31:0] ram     [0:8191];
  logic [31:0] ref_mem [0:8191];

  assign bus.ram_data = ram[bus.ram_addr[14:2]];
  always @(posedge clk) if (bus.ram_we) ram[bus.ram_addr[14:2]] <= bus.ram_wd;

  typedef struct {
    logic        ready;
    logic        done;
    logic        fault;
    logic        we;
    logic [31:0] rdata;
    logic [31:0] raddr;
    logic [31:0] wd;
  } cyc_t;

  cyc_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model_rdata = 32'd0;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic cyc_t mk(input logic rdy, input logic dn, input logic flt, input logic we,
                              input logic [31:0] rd, input logic [31:0] ra,
                              input logic [31:0] wd);
    cyc_t c;
    c.ready = rdy; c.done = dn; c.fault = flt; c.we = we;
    c.rdata = rd;  c.raddr = ra; c.wd = wd;
    return c;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      cyc_t e;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = mk(1'b1, 1'b0, 1'b0, 1'b0, model_rdata, 32'd0, 32'd0);
      chk("ready", {31'd0, bus.ready}, {31'd0, e.ready});
      chk("done", {31'd0, bus.done}, {31'd0, e.done});
      chk("fault", {31'd0, bus.fault}, {31'd0, e.fault});
      chk("ram_we", {31'd0, bus.ram_we}, {31'd0, e.we});
      chk("rdata", bus.rdata, e.rdata);
      chk("ram_addr", bus.ram_addr, e.raddr);
      chk("ram_wd", bus.ram_wd, e.wd);
    end
  end

  // Transaction-level prediction: pushes one record per cycle after acceptance.
  task automatic predict(input logic wr, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, output int n);
    int          nb, off, idx;
    longint      last;
    logic        bad;
    logic [31:0] old, al, w, v;
    old  = model_rdata;
    al   = {addr[31:2], 2'b00};
    off  = int'(addr[1:0]);
    idx  = int'(addr[14:2]);
    nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    last = longint'(addr) + nb - 1;
    bad  = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    if (BoundsEn && last >= 32768) bad = 1'b1;
    if (bad) begin
      exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, old, 32'd0, 32'd0));
      n = 1;
    end else if (!wr) begin
      w = ref_mem[idx];
      v = 32'd0;
      for (int b = 0; b < nb; b++) v[8*b +: 8] = w[8*(off+b) +: 8];
      if (!uns && nb < 4 && v[8*nb-1]) for (int b = 8 * nb; b < 32; b++) v[b] = 1'b1;
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, old, al, 32'd0));
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, v, 32'd0, 32'd0));
      model_rdata = v;
      n = 2;
    end else if (nb == 4) begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, old, al, wdata));
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, old, 32'd0, 32'd0));
      ref_mem[idx] = wdata;
      n = 2;
    end else begin
      w = ref_mem[idx];
      for (int b = 0; b < nb; b++) w[8*(off+b) +: 8] = wdata[8*b +: 8];
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, old, al, 32'd0));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, old, al, w));
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, old, 32'd0, 32'd0));
      ref_mem[idx] = w;
      n = 3;
    end
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Entered 2 time units after a rising edge with the DUT idle; returns likewise.
  task automatic issue(input logic wr, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, output int n);
    bus.req = 1'b1; bus.wr = wr; bus.size = size; bus.uns = uns;
    bus.addr = addr; bus.wdata = wdata;
    @(posedge clk);
    #2;
    predict(wr, size, uns, addr, wdata, n);
    for (int i = 0; i < n; i++) begin
      // Junk while busy: must be ignored and must not disturb the latched request.
      bus.req = 1'($urandom_range(0, 1)); bus.wr = 1'($urandom_range(0, 1));
      bus.size = 2'($urandom_range(0, 3)); bus.uns = 1'($urandom_range(0, 1));
      bus.addr = $urandom; bus.wdata = $urandom;
      @(posedge clk);
      #2;
    end
    bus.req = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] saved;
    bus.req = 1'b0; bus.wr = 1'b0; bus.size = 2'd0; bus.uns = 1'b0;
    bus.addr = 32'd0; bus.wdata = 32'd0;
    for (int i = 0; i < 8192; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    ram[64] = 32'h8899AABB;
    ref_mem[64] = 32'h8899AABB;

    rst = 1'b1;
    #1;
    chk("rst_ready", {31'd0, bus.ready}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_fault", {31'd0, bus.fault}, 32'd0);
    chk("rst_ram_we", {31'd0, bus.ram_we}, 32'd0);
    chk("rst_ram_addr", bus.ram_addr, 32'd0);
    chk("rst_ram_wd", bus.ram_wd, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, bus.ready}, 32'd1);
    #1;
    mon_en = 1'b1;

    issue(1'b0, 2'd0, 1'b0, 32'h101, 32'd0, n);
    chk("lat_lb", n, 2);
    chk("model_lb", model_rdata, 32'hFFFFFFAA);
    idle(1);
    chk("lit_lb", bus.rdata, 32'hFFFFFFAA);

    issue(1'b0, 2'd1, 1'b1, 32'h102, 32'd0, n);
    idle(1);
    chk("lit_lhu", bus.rdata, 32'h00008899);

    issue(1'b1, 2'd0, 1'b0, 32'h102, 32'h12, n);
    chk("lat_sb", n, 3);
    idle(1);
    chk("lit_sb_mem", ram[64], 32'h8812AABB);
    chk("lit_sb_rdata", bus.rdata, 32'h00008899);

    saved = ram[128];
    issue(1'b1, 2'd2, 1'b0, 32'h203, 32'hDEADBEEF, n);
    chk("lat_sw_mis", n, 1);
    idle(1);
    chk("lit_sw_mis_mem", ram[128], saved);

    issue(1'b0, 2'd2, 1'b0, 32'h7FFE, 32'd0, n);
    chk("lat_lw_7ffe", n, 1);
    issue(1'b0, 2'd2, 1'b0, 32'h8000, 32'd0, n);
    chk("lat_lw_8000", n, BoundsEn ? 1 : 2);
    issue(1'b0, 2'd2, 1'b0, 32'h7FFC, 32'd0, n);
    chk("lat_lw_7ffc", n, 2);
    idle(2);

    // Halfword store aborted by reset while in the write cycle.
    mon_en = 1'b0;
    saved = ram[66];
    bus.req = 1'b1; bus.wr = 1'b1; bus.size = 2'd1; bus.uns = 1'b0;
    bus.addr = 32'h10A; bus.wdata = 32'h5A5A;
    @(posedge clk);
    #2;
    bus.req = 1'b0;
    @(posedge clk);
    #2;
    chk("abort_we_before", {31'd0, bus.ram_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_we", {31'd0, bus.ram_we}, 32'd0);
    chk("abort_ready", {31'd0, bus.ready}, 32'd0);
    chk("abort_ram_wd", bus.ram_wd, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    model_rdata = 32'd0;
    mon_en = 1'b1;
    idle(3);
    chk("abort_mem", ram[66], saved);

    for (int t = 0; t < 300; t++) begin
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'h100 + 32'($urandom_range(0, 255)), $urandom, n);
      idle($urandom_range(0, 2));
    end
    idle(2);

    for (int i = 60; i < 132; i++) chk("mem_sweep", ram[i], ref_mem[i]);
    chk("mem_top", ram[8191], ref_mem[8191]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
